// File: rtl/serial_word_feeder.sv
// serial_word_feeder: takes a parallel word, shifts it out MSB first with a
// per-bit valid, frame start/last markers and a clear pulse for the
// downstream remainder checker, then idles for GAP cycles before taking the
// next word.
module serial_word_feeder #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             pause,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             chk_clr,
  output logic             busy
);

  // Counter widths: enough to hold WIDTH-1 and GAP-1, never narrower than 1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam int BTOP_I = WIDTH - 1;
  localparam int GTOP_I = (GAP > 0) ? (GAP - 1) : 0;

  localparam logic [CW-1:0] BCNT_TOP = CW'(BTOP_I);
  localparam logic [GW-1:0] GCNT_TOP = GW'(GTOP_I);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bcnt;
  logic [GW-1:0]    gcnt;
  logic             accept;
  logic             in_shift;

  // Handshake and serial outputs are pure decodes of the registered state;
  // reset gates the ready/clear path so nothing is taken while held in reset.
  always_comb begin
    in_shift    = (state == S_SHIFT);
    busy        = (state != S_IDLE);
    word_ready  = (state == S_IDLE) && !reset;
    accept      = word_valid && word_ready;
    chk_clr     = accept;
    bit_valid   = in_shift && !pause;
    bit_out     = in_shift && sreg[WIDTH-1];
    frame_start = bit_valid && (bcnt == BCNT_TOP);
    frame_last  = bit_valid && (bcnt == '0);
  end

  // State, shift register and both counters; the word is captured only on
  // accept, so word_in/word_valid activity while busy cannot disturb a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sreg  <= '0;
      bcnt  <= '0;
      gcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg  <= word_in;
            bcnt  <= BCNT_TOP;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // A paused cycle holds everything so bit_out stays put.
          if (!pause) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            if (bcnt == '0) begin
              if (GAP > 0) begin
                gcnt  <= GCNT_TOP;
                state <= S_GAP;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bcnt <= bcnt - 1'b1;
            end
          end
        end
        S_GAP: begin
          // Idle spacing between frames; pause is deliberately ignored here.
          if (gcnt == '0) begin
            state <= S_IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=8, GAP=1). The downstream
// checker is modelled here as a running remainder modulo 5 of the serial
// stream, cleared by chk_clr.
module tb_serial_word_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       pause;
  logic       bit_out;
  logic       bit_valid;
  logic       frame_start;
  logic       frame_last;
  logic       chk_clr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_word_feeder #(.WIDTH(8), .GAP(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .pause       (pause),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_last  (frame_last),
    .chk_clr     (chk_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  word;
    logic [15:0] pmask;      // pause value for cycle c after accept (bit c-1)
    logic        toggle;     // wiggle word_valid/word_in while busy
    logic [7:0]  exp_bits;
    int          exp_ready;  // cycle after accept where word_ready returns
    logic        exp_div;    // stream value divisible by 5
  } vec_t;

  vec_t tbl[5];

  task automatic run_frame(input vec_t v);
    logic [7:0] got;
    int nb, ns, nl, ready_at, early, rem;
    got = '0; nb = 0; ns = 0; nl = 0; ready_at = -1; early = 0; rem = 0;
    @(posedge clk); #1;
    word_in = v.word; word_valid = 1'b1; pause = 1'b0;
    @(negedge clk);
    chk({v.name, "/accept_ready"}, word_ready, 1);
    chk({v.name, "/accept_chk_clr"}, chk_clr, 1);
    @(posedge clk); #1;
    word_valid = 1'b0;
    word_in = v.toggle ? 8'h00 : ~v.word;
    for (int c = 1; c <= 40 && ready_at < 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      pause = (c <= 16) ? v.pmask[c-1] : 1'b0;
      if (v.toggle) word_valid = c[0];
      @(negedge clk);
      if (busy && chk_clr) early++;
      if (frame_start) ns++;
      if (frame_last) nl++;
      if (bit_valid) begin
        chk({v.name, "/start_pos"}, frame_start, (nb == 0));
        chk({v.name, "/last_pos"}, frame_last, (nb == 7));
        if (nb < 8) got[7-nb] = bit_out;
        rem = (rem * 2 + int'(bit_out)) % 5;
        nb++;
      end else if (busy && pause && nb < 8) begin
        chk({v.name, "/pause_hold"}, bit_out, v.exp_bits[7-nb]);
      end
      if (word_ready) ready_at = c;
    end
    word_valid = 1'b0; pause = 1'b0;
    chk({v.name, "/bits"}, got, v.exp_bits);
    chk({v.name, "/nbits"}, nb, 8);
    chk({v.name, "/n_start"}, ns, 1);
    chk({v.name, "/n_last"}, nl, 1);
    chk({v.name, "/ready_cycle"}, ready_at, v.exp_ready);
    chk({v.name, "/busy_accepts"}, early, 0);
    chk({v.name, "/divisible"}, (rem == 0), v.exp_div);
  endtask

  initial begin
    tbl[0] = '{"f0F", 8'h0F, 16'h0000, 1'b0, 8'h0F, 10, 1'b1};
    tbl[1] = '{"fA5", 8'hA5, 16'h000C, 1'b0, 8'hA5, 12, 1'b1};
    tbl[2] = '{"f19", 8'h19, 16'h0100, 1'b0, 8'h19, 10, 1'b1};
    tbl[3] = '{"f1A", 8'h1A, 16'h0000, 1'b0, 8'h1A, 10, 1'b0};
    tbl[4] = '{"f80", 8'h80, 16'h0000, 1'b1, 8'h80, 10, 1'b0};

    // Reset: everything low, ready/clear forced low even with word_valid=1.
    reset = 1'b1; word_valid = 1'b1; word_in = 8'hFF; pause = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst/outputs", {bit_out, bit_valid, frame_start, frame_last, busy}, 0);
    chk("rst/ready", word_ready, 0);
    chk("rst/chk_clr", chk_clr, 0);
    @(posedge clk); #1;
    word_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst/ready_after", word_ready, 1);
    chk("rst/busy_after", busy, 0);

    foreach (tbl[i]) run_frame(tbl[i]);

    // Back-to-back with word_valid held high: 0x3C then 0x19.
    begin
      int acc, a0, a1, nb2;
      logic [7:0] got2;
      acc = 0; a0 = -1; a1 = -1; nb2 = 0; got2 = '0;
      @(posedge clk); #1;
      word_in = 8'h3C; word_valid = 1'b1;
      for (int c = 0; c < 36; c++) begin
        if (c > 0) begin @(posedge clk); #1; end
        if (acc == 1 && c == a0 + 1) word_in = 8'h19;
        if (acc >= 2 && c == a1 + 1) word_valid = 1'b0;
        @(negedge clk);
        if (chk_clr) begin
          if (acc == 0) a0 = c;
          else if (acc == 1) a1 = c;
          acc++;
        end
        if (acc == 2 && c > a1 && bit_valid && nb2 < 8) begin
          got2[7-nb2] = bit_out;
          nb2++;
        end
      end
      word_valid = 1'b0;
      chk("b2b/accepts", acc, 2);
      chk("b2b/period", a1 - a0, 10);
      chk("b2b/second_bits", got2, 8'h19);
    end

    // Reset while bit 5 of 0xFF is on the line.
    begin
      int nb, nl;
      nb = 0; nl = 0;
      @(posedge clk); #1;
      word_in = 8'hFF; word_valid = 1'b1;
      @(posedge clk); #1;
      word_valid = 1'b0;
      for (int c = 1; c <= 20 && nb < 4; c++) begin
        if (c > 1) begin @(posedge clk); #1; end
        @(negedge clk);
        if (bit_valid) nb++;
        if (frame_last) nl++;
      end
      @(posedge clk); #1;
      chk("abort/bit5_valid", {bit_valid, bit_out}, 2'b11);
      reset = 1'b1; word_valid = 1'b1;
      #1;
      chk("abort/outputs_async", {bit_out, bit_valid, frame_start, frame_last, busy, word_ready, chk_clr}, 0);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        if (frame_last) nl++;
        @(posedge clk); #1;
      end
      word_valid = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("abort/ready_after", word_ready, 1);
      chk("abort/busy_after", busy, 0);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (frame_last || bit_valid) nl++;
      end
      chk("abort/no_last", nl, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 Parameter: WIDTH, default 8, number of bits per word (legal range 2..32).
REQ-002 Parameter: GAP, default 1, number of idle cycles inserted after each frame (legal range 0..15).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: word_in  input  WIDTH  parallel word to serialise.
REQ-006 Port: word_valid  input  1  word_in is valid.
REQ-007 Port: word_ready  output  1  feeder can accept a word this cycle.
REQ-008 Port: pause  input  1  stall request; holds the current bit.
REQ-009 Port: bit_out  output  1  serial bit, MSB first, drives the downstream serial remainder checker's data input.
REQ-010 Port: bit_valid  output  1  bit_out is consumed on this edge.
REQ-011 Port: frame_start  output  1  bit_out is the first bit of a word.
REQ-012 Port: frame_last  output  1  bit_out is the last bit of a word.
REQ-013 Port: chk_clr  output  1  clear pulse for the downstream checker's state.
REQ-014 Port: busy  output  1  feeder is not in IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-016 word_ready SHALL be 1 only in IDLE.
REQ-017 An accept occurs on an edge where word_valid=1 and word_ready=1.
REQ-018 On accept: shift register loads word_in; bit counter loads WIDTH-1; state goes to SHIFT.
REQ-019 chk_clr SHALL be combinational and equal to (word_valid AND word_ready), so the checker is cleared during the cycle before the first bit.
REQ-020 In SHIFT, bit_out SHALL equal the shift register MSB; in IDLE and GAP, bit_out SHALL be 0.
REQ-021 bit_valid SHALL equal (state==SHIFT AND pause==0).
REQ-022 pause SHALL be ignored outside SHIFT.
REQ-023 On an edge with bit_valid=1: shift register shifts left by one with 0 fill, and the counter decrements.
REQ-024 On an edge with bit_valid=0 in SHIFT: shift register and counter hold, and bit_out is stable.
REQ-025 frame_start SHALL equal (bit_valid AND counter==WIDTH-1).
REQ-026 frame_last SHALL equal (bit_valid AND counter==0).
REQ-027 On a frame_last edge: state goes to GAP with the gap counter set to GAP-1 if GAP>0; otherwise state goes directly to IDLE.
REQ-028 In GAP: the gap counter decrements each cycle, and state goes to IDLE on the edge where the gap counter is 0; pause has no effect.
REQ-029 Changes on word_in or word_valid while busy=1 SHALL NOT affect the frame in progress.
REQ-030 A word presented while busy SHALL be accepted on the first IDLE cycle in which word_valid is still 1.
REQ-031 With word_valid held high, the accept-to-accept period SHALL be exactly 1+WIDTH+GAP cycles when there is no pause.
REQ-032 busy SHALL equal (state!=IDLE).
REQ-033 Counters SHALL be sized ceil(log2(WIDTH)) and ceil(log2(GAP+1)) bits, minimum 1 bit, with no wrap beyond their terminal values.

Reset
REQ-034 While reset=1, the following SHALL hold regardless of clk:
- state = IDLE
- shift register = 0, bit counter = 0, gap counter = 0
- bit_out, bit_valid, frame_start, frame_last, busy = 0
REQ-035 While reset=1, word_ready and chk_clr SHALL be forced to 0.
REQ-036 A reset during SHIFT SHALL abort the frame with no frame_last.
REQ-037 After reset deasserts, word_ready SHALL be 1 in the first cycle.

Verification (WIDTH=8, GAP=1)
REQ-038 Accept 0x0F, pause=0 -> chk_clr=1 in the accept cycle; bit_out 0,0,0,0,1,1,1,1 on 8 consecutive bit_valid cycles; frame_start on bit 1, frame_last on bit 8; 1 GAP cycle; word_ready=1 on the 10th cycle after accept.
REQ-039 Accept 0xA5; pause=1 for 2 cycles while bit 3 (value 1) is presented -> bit_valid=0 for those 2 cycles with bit_out held at 1; full sequence 1,0,1,0,0,1,0,1; frame lasts 10 cycles.
REQ-040 word_valid held high, 0x3C then 0x19 -> accepts exactly 10 cycles apart; second frame is 0,0,0,1,1,0,0,1; chk_clr pulses exactly twice.
REQ-041 Accept 0xFF, assert reset during bit 5 -> all outputs 0 immediately; no frame_last; word_ready=1 in the first cycle after reset release.
REQ-042 Accept 0x80, then change word_in to 0x00 and toggle word_valid during SHIFT -> output is still 1,0,0,0,0,0,0,0; no accept until IDLE.
REQ-043 Feeder driving the checker with 0x19 (25) -> checker reports divisible on the final bit; with 0x1A (26) -> not divisible.
